// File: rtl/adder_pkg.sv
// Shared definitions for the adder result path: widths and the accumulator FSM states.
package adder_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned SAMPLE_W = NIBBLE_W + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/adder_result_accumulator_if.sv
// Sample-in / batch-out handshake bundle for the adder result accumulator.
interface adder_result_accumulator_if #(
    parameter int unsigned ACC_W = 8
);
    import adder_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [NIBBLE_W-1:0] in_sum;
    logic                in_cout;
    logic                out_valid;
    logic                out_ready;
    logic [ACC_W-1:0]    out_acc;
    logic                out_ovf;

    modport master (
        output in_valid, in_sum, in_cout, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, in_cout, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );

endinterface

// File: rtl/acc_datapath.sv
// Combinational ACC_W+1-bit adder: running total plus zero-extended sample, with carry out.
module acc_datapath
    import adder_pkg::*;
#(
    parameter int unsigned ACC_W = 8
) (
    input  logic [ACC_W-1:0]    acc_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic [ACC_W-1:0]    sum_o,
    output logic                carry_o
);

    logic [ACC_W:0] wide_sum;

    always_comb begin
        wide_sum = {1'b0, acc_i} + {{(ACC_W + 1 - SAMPLE_W){1'b0}}, sample_i};
        sum_o    = wide_sum[ACC_W-1:0];
        carry_o  = wide_sum[ACC_W];
    end

endmodule

// File: rtl/adder_result_accumulator.sv
// Sums COUNT accepted adder results into an ACC_W-bit total with a sticky overflow flag,
// then holds the total on the output handshake until taken.
module adder_result_accumulator
    import adder_pkg::*;
#(
    parameter int unsigned ACC_W = 8,
    parameter int unsigned COUNT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    adder_result_accumulator_if.slave  bus
);

    localparam int unsigned CntW = $clog2(COUNT + 1);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [ACC_W-1:0] sum;
    logic             carry;

    acc_datapath #(
        .ACC_W (ACC_W)
    ) u_acc_datapath (
        .acc_i    (acc_q),
        .sample_i ({bus.in_cout, bus.in_sum}),
        .sum_o    (sum),
        .carry_o  (carry)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        if (clear) begin
            // Abort wins over any offered sample or pending transfer.
            state_d     = ACCUM;
            acc_d       = '0;
            ovf_d       = 1'b0;
            cnt_d       = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_d = sum;
                        ovf_d = ovf_q | carry;
                        if (cnt_q == CntW'(COUNT - 1)) begin
                            cnt_d       = '0;
                            state_d     = HOLD;
                            in_ready_d  = 1'b0;
                            out_valid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        acc_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = ACCUM;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = acc_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: doc/adder_result_accumulator.md
# adder_result_accumulator

Sequential stage directly downstream of the 4-bit ripple adder. It consumes the adder's {cout, sum} result under a valid/ready handshake and sums COUNT consecutive accepted results into an ACC_W-bit accumulator. It then presents the batch total, with a sticky overflow flag, on a valid/ready output port. Typical use is as the consumer of adder results in simulator test benches and in multi-cycle datapaths.

## Interface
- ACC_W, default 8: accumulator width in bits; legal range ≥ 5.
- COUNT, default 4: accepted samples per batch; legal range ≥ 1.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- clear  input  1  synchronous batch abort.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_sum  input  4  adder sum[3:0].
- in_cout  input  1  adder carry-out.
- out_valid  output  1  batch result available.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  batch total, modulo 2^ACC_W.
- out_ovf  output  1  at least one carry out of bit ACC_W-1 occurred during the batch.

## Operation
- Sample value v = {in_cout, in_sum}, zero-extended to ACC_W bits. The range of v is 0..31.
- State machine with two states, ACCUM and HOLD. The encoding is an enum in the package.
- **ACCUM state**
  - in_ready=1 and out_valid=0.
  - On in_valid & in_ready: acc <= acc + v (mod 2^ACC_W); ovf <= ovf | carry; cnt <= cnt + 1.
  - On the COUNT-th accepted sample (cnt == COUNT-1), the final sum and ovf are registered, cnt returns to 0, and the state moves to HOLD.
  - Cycles with in_valid=0 do not count toward the batch.
- **HOLD state**
  - in_ready=0 and out_valid=1.
  - out_acc and out_ovf are stable while out_valid=1 and out_ready=0.
  - in_valid is ignored and no sample is consumed.
  - On out_ready=1: transfer completes, acc and ovf clear to 0, and the state returns to ACCUM.
- **clear**
  - In either state: acc=0, ovf=0, cnt=0, next state ACCUM.
  - Any sample offered in the same cycle is dropped.
  - Any result pending in HOLD is discarded, even if out_ready=1.
- **Priority:** rst > clear > handshake.
- **Counter:** cnt width is $clog2(COUNT+1). It wraps only through the batch-complete transition.

## Timing
- Reset values: state=ACCUM, in_ready=1, out_valid=0, out_acc=0, out_ovf=0, internal acc=0, cnt=0.
- rst asserted mid-batch or in HOLD: the reset values above hold from the next edge, and any pending data is lost.
- All outputs are registered or decoded from state only. There is no combinational path from in_* or out_ready to outputs.
- Latency: out_valid rises on the edge that accepts the COUNT-th sample, i.e. it is visible the cycle after that sample is presented.
- Throughput: one sample per cycle in ACCUM. Each batch costs at least one extra cycle in HOLD, because in_ready=0 there. There is no bypass from output acceptance to input acceptance.
- COUNT=1: every accepted sample goes straight to HOLD, and out_acc = v.
- Simultaneous out_ready and in_valid in HOLD: the result is transferred and the sample is not accepted. The sample must be re-presented in the following ACCUM cycle.

## Structure
- Shared package adder_pkg contains:
  - NIBBLE_W = 4.
  - SAMPLE_W = NIBBLE_W + 1.
  - The acc_state_t enum {ACCUM, HOLD}.
- One sub-module is natural: acc_datapath. It is the ACC_W+1-bit adder that produces the next sum and the carry, and it is purely combinational.
- The FSM, counter and registers live in the top module.

## Test plan
1. **Reset.** Assert rst for 2 cycles, then release. Required: in_ready=1, out_valid=0, out_acc=0, out_ovf=0.
2. **Basic batch** (ACC_W=8, COUNT=4). Samples {0,5}, {1,3}, {0,15}, {1,0}, with in_valid gaps between them. Required: out_valid=1 the cycle after the 4th accept, out_acc=0x37 (55), out_ovf=0.
3. **Backpressure.** Hold out_ready=0 for 3 cycles in HOLD while in_valid=1. Required: out_acc is held constant, in_ready=0, no samples are consumed, and the next batch starts from acc=0.
4. **Overflow** (ACC_W=8, COUNT=9). Nine samples of {1,0xF} (31). Required: out_acc=0x17 (279 mod 256), out_ovf=1. Next batch: 9 samples of 1 give out_acc=9, out_ovf=0.
5. **clear.** Pulse clear after 2 accepted samples, then send 4 samples of {0,1}. Required: out_acc=4. A further clear pulsed in HOLD drops the result and returns in_ready=1 on the next cycle.
6. **Reset in HOLD.** Assert rst while out_valid=1 and out_ready=1. Required: the transfer is not counted, and on the next cycle all outputs equal their reset values.
